// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding UART_TX through its start/busy handshake.
// Bytes are popped one at a time; a missing busy response abandons the byte after BUSY_TIMEOUT cycles.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       timeout,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [WIDTH-1:0]           tx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_next;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             timeout_hit;

  // A push against a full queue is dropped even if a pop frees a slot this cycle.
  assign push = wr_en && !full;

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          timer_next = '0;
          state_next = WAIT_BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage is left unreset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      tx_start <= pop;
      count    <= count_next;
      full     <= (count_next == CW'(DEPTH));
      empty    <= (count_next == CW'(0));
      overflow <= overflow | (wr_en && full);
      timeout  <= timeout | timeout_hit;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule
